// File: rtl/divider_iter.sv
// Iterative restoring divider for the execute stage.
// Retires BPC quotient bits per clock over WIDTH/BPC iterations and serves
// DIV/DIVU/REM/REMU. Divide-by-zero and signed overflow finish in one cycle
// without entering CALC. A kill flushes the operation in flight and leaves
// the last completed result on the outputs.

module divider_iter #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             kill_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = $clog2(N + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    localparam logic [CW-1:0]    CNT_LOAD = CW'(N);
    localparam logic [CW-1:0]    CNT_LAST = CW'(1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Two's-complement negation.
    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Absolute value when the operand is interpreted as signed.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? twos_neg(v) : v;
    endfunction

    // Registered state
    logic [0:0]       state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] prem_q,      prem_d;      // partial remainder (always < divisor)
    logic [WIDTH-1:0] quo_q,       quo_d;       // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q,       dvs_d;       // divisor magnitude
    logic             rem_sel_q,   rem_sel_d;   // result_o returns the remainder
    logic             neg_quo_q,   neg_quo_d;
    logic             neg_rem_q,   neg_rem_d;
    logic             busy_q,      busy_d;
    logic             ready_q,     ready_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [WIDTH-1:0] result_q,    result_d;

    // Combinational helpers
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] step_prem_s;
    logic [WIDTH-1:0] step_quo_s;
    logic [WIDTH-1:0] fin_quo_s;
    logic [WIDTH-1:0] fin_rem_s;
    logic             req_signed_s;
    logic             req_rem_s;
    logic             req_overflow_s;

    // Chain of BPC restoring compare/subtract stages; the borrow bit of the
    // (WIDTH+1)-bit difference decides whether the subtraction is kept.
    always_comb begin
        step_prem_s = prem_q;
        step_quo_s  = quo_q;
        shifted_s   = {(WIDTH+1){1'b0}};
        diff_s      = {(WIDTH+1){1'b0}};
        for (int k = 0; k < BPC; k++) begin
            shifted_s  = {step_prem_s, step_quo_s[WIDTH-1]};
            diff_s     = shifted_s - {1'b0, dvs_q};
            step_quo_s = {step_quo_s[WIDTH-2:0], ~diff_s[WIDTH]};
            if (diff_s[WIDTH]) begin
                step_prem_s = shifted_s[WIDTH-1:0];
            end else begin
                step_prem_s = diff_s[WIDTH-1:0];
            end
        end
        fin_quo_s = neg_quo_q ? twos_neg(step_quo_s)  : step_quo_s;
        fin_rem_s = neg_rem_q ? twos_neg(step_prem_s) : step_prem_s;
    end

    // Request decode; any op that is not one-hot div/rem/remu behaves as divu.
    always_comb begin
        req_signed_s   = (op_i == 4'b1000) || (op_i == 4'b0010);
        req_rem_s      = (op_i == 4'b0010) || (op_i == 4'b0001);
        req_overflow_s = req_signed_s && (dividend_i == MOST_NEG) && (divisor_i == ALL_ONES);
    end

    // Next-state logic for the IDLE/CALC controller and the datapath registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prem_d      = prem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        rem_sel_d   = rem_sel_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        busy_d      = busy_q;
        ready_d     = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        result_d    = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rem_sel_d = req_rem_s;
                    if (divisor_i == ALL_ZERO) begin
                        // Divide by zero: raw dividend as remainder, no sign fixup.
                        ready_d     = 1'b1;
                        busy_d      = 1'b0;
                        quotient_d  = ALL_ONES;
                        remainder_d = dividend_i;
                        result_d    = req_rem_s ? dividend_i : ALL_ONES;
                    end else if (req_overflow_s) begin
                        // MOST_NEG / -1 wraps back to MOST_NEG with zero remainder.
                        ready_d     = 1'b1;
                        busy_d      = 1'b0;
                        quotient_d  = dividend_i;
                        remainder_d = ALL_ZERO;
                        result_d    = req_rem_s ? ALL_ZERO : dividend_i;
                    end else begin
                        state_d   = S_CALC;
                        busy_d    = 1'b1;
                        cnt_d     = CNT_LOAD;
                        prem_d    = ALL_ZERO;
                        quo_d     = magnitude(dividend_i, req_signed_s);
                        dvs_d     = magnitude(divisor_i, req_signed_s);
                        neg_quo_d = req_signed_s && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        neg_rem_d = req_signed_s && dividend_i[WIDTH-1];
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_CALC: begin
                if (kill_i) begin
                    // Flush: drop the operation, keep the last completed outputs.
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    prem_d = step_prem_s;
                    quo_d  = step_quo_s;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d     = S_IDLE;
                        busy_d      = 1'b0;
                        ready_d     = 1'b1;
                        quotient_d  = fin_quo_s;
                        remainder_d = fin_rem_s;
                        result_d    = rem_sel_q ? fin_rem_s : fin_quo_s;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            prem_q      <= ALL_ZERO;
            quo_q       <= ALL_ZERO;
            dvs_q       <= ALL_ZERO;
            rem_sel_q   <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            quotient_q  <= ALL_ZERO;
            remainder_q <= ALL_ZERO;
            result_q    <= ALL_ZERO;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            rem_sel_q   <= rem_sel_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            result_q    <= result_d;
        end
    end

    assign busy_o      = busy_q;
    assign ready_o     = ready_q;
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;
    assign result_o    = result_q;

    divider_iter_chk #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .busy_o  (busy_q),
        .ready_o (ready_q),
        .op_i    (op_i)
    );

endmodule

// Simulation-only checks for divider_iter.
module divider_iter_chk #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input logic       clk,
    input logic       rst,
    input logic       start_i,
    input logic       busy_o,
    input logic       ready_o,
    input logic [3:0] op_i
);

    if (((WIDTH % 2) != 0) || (WIDTH < 8) || !((BPC == 1) || (BPC == 2) || (BPC == 4))
        || ((WIDTH % BPC) != 0)) begin : g_bad_param
        $error("divider_iter: illegal WIDTH/BPC combination");
    end

    // Accepted requests must carry a one-hot op; busy and ready never overlap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (start_i && !busy_o) begin
                assert ($onehot(op_i));
            end
            assert (!(busy_o && ready_o));
        end
    end

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter: directed 32-bit scenarios on BPC=1
// and BPC=4 instances, then a randomised 16-bit sweep over BPC 1/2/4
// against an arithmetic reference model.

module tb_divider_iter;

    localparam int NI = 5;

    localparam logic [3:0] OP_DIV  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b0100;
    localparam logic [3:0] OP_REM  = 4'b0010;
    localparam logic [3:0] OP_REMU = 4'b0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [NI];
    logic [3:0]  op    [NI];
    logic [31:0] dvd   [NI];
    logic [31:0] dvs   [NI];
    logic        kill  [NI];
    logic        busy  [NI];
    logic        ready [NI];
    logic [31:0] res_o [NI];
    logic [31:0] quo_o [NI];
    logic [31:0] rem_o [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instances: 0 = 32/BPC1, 1 = 32/BPC4, 2 = 16/BPC1, 3 = 16/BPC2, 4 = 16/BPC4
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = (g < 2) ? 32 : 16;
        localparam int B = (g == 1 || g == 4) ? 4 : ((g == 3) ? 2 : 1);
        logic [W-1:0] res_l, quo_l, rem_l;
        divider_iter #(.WIDTH(W), .BPC(B)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start_i     (start[g]),
            .op_i        (op[g]),
            .dividend_i  (dvd[g][W-1:0]),
            .divisor_i   (dvs[g][W-1:0]),
            .kill_i      (kill[g]),
            .busy_o      (busy[g]),
            .ready_o     (ready[g]),
            .result_o    (res_l),
            .quotient_o  (quo_l),
            .remainder_o (rem_l)
        );
        assign res_o[g] = 32'(res_l);
        assign quo_o[g] = 32'(quo_l);
        assign rem_o[g] = 32'(rem_l);
    end

    function automatic int bpc_of(input int k);
        case (k)
            1, 4:    return 4;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    // Reference: plain integer division with the special-case rules.
    function automatic void ref_div(input int w, input logic [3:0] o,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        logic [31:0] mask;
        longint      sa, sb;
        logic [63:0] tq, tr;
        bit          sgn;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        sgn  = (o == OP_DIV) || (o == OP_REM);
        if (b == 32'd0) begin
            q = mask;
            r = a;
        end else if (sgn) begin
            sa = longint'(a);
            sb = longint'(b);
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[31:0] & mask;
            r  = tr[31:0] & mask;
        end else begin
            tq = longint'(a) / longint'(b);
            tr = longint'(a) % longint'(b);
            q  = tq[31:0];
            r  = tr[31:0];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int i, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b);
        start[i] = 1'b1;
        op[i]    = o;
        dvd[i]   = a;
        dvs[i]   = b;
    endtask

    // Called in the start cycle (cycle 0). Walks to the ready cycle (or past
    // the kill point), checking busy/ready every cycle, then the outputs.
    task automatic expect_run(input int i, input int lat, input int kill_at, input int stray_at,
                              input logic [31:0] eq, input logic [31:0] er,
                              input logic [31:0] eres, input string tag);
        int last;
        bit exp_busy, exp_ready;
        last = (kill_at > 0) ? lat + 1 : lat;
        for (int c = 1; c <= last; c++) begin
            tick();
            if (c == 1) start[i] = 1'b0;
            if (c == stray_at) begin
                start[i] = 1'b1; op[i] = OP_DIVU; dvd[i] = 32'd5; dvs[i] = 32'd1;
            end else if (stray_at > 0 && c == stray_at + 1) begin
                start[i] = 1'b0;
            end
            exp_busy  = (kill_at > 0) ? (c <= kill_at) : (c < lat);
            exp_ready = (kill_at == 0) && (c == lat);
            chk($sformatf("%s busy c%0d", tag, c), {31'b0, busy[i]}, {31'b0, exp_busy});
            chk($sformatf("%s ready c%0d", tag, c), {31'b0, ready[i]}, {31'b0, exp_ready});
            kill[i] = (c == kill_at);
        end
        kill[i] = 1'b0;
        chk({tag, " quotient"}, quo_o[i], eq);
        chk({tag, " remainder"}, rem_o[i], er);
        chk({tag, " result"}, res_o[i], eres);
    endtask

    task automatic expect_cleared(input int i, input string tag);
        chk({tag, " busy"}, {31'b0, busy[i]}, 32'd0);
        chk({tag, " ready"}, {31'b0, ready[i]}, 32'd0);
        chk({tag, " quotient"}, quo_o[i], 32'd0);
        chk({tag, " remainder"}, rem_o[i], 32'd0);
        chk({tag, " result"}, res_o[i], 32'd0);
    endtask

    // Hard stop in case anything blocks.
    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  o;
        logic [31:0] a, b, eq, er, eres;
        bit          sp, sgn;
        int          lat;

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0; op[i] = 4'b0000; dvd[i] = 32'd0; dvs[i] = 32'd0; kill[i] = 1'b0;
        end
        tick();
        tick();
        for (int i = 0; i < NI; i++) expect_cleared(i, $sformatf("reset%0d", i));
        rst = 1'b0;
        tick();

        // divu 100/7, BPC=1
        issue(0, OP_DIVU, 32'd100, 32'd7);
        expect_run(0, 33, 0, 0, 32'd14, 32'd2, 32'd14, "divu100_7");
        tick();
        chk("divu100_7 hold q", quo_o[0], 32'd14);
        chk("divu100_7 ready low", {31'b0, ready[0]}, 32'd0);

        // Divide by zero and signed overflow
        issue(0, OP_DIV, 32'h1234_5678, 32'd0);
        expect_run(0, 1, 0, 0, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, "div_by0");
        tick();
        chk("div_by0 busy", {31'b0, busy[0]}, 32'd0);
        issue(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_run(0, 1, 0, 0, 32'h8000_0000, 32'd0, 32'h8000_0000, "div_ovf");
        tick();

        // Stray start in cycle 5 is ignored
        issue(0, OP_DIVU, 32'd1000, 32'd10);
        expect_run(0, 33, 0, 5, 32'd100, 32'd0, 32'd100, "stray_start");
        tick();

        // Kill in cycle 10: no ready, outputs keep previous result
        issue(0, OP_DIVU, 32'hFFFF_FFFF, 32'd3);
        expect_run(0, 33, 10, 0, 32'd100, 32'd0, 32'd100, "kill");
        tick();

        // BPC=4: div -7/2 then rem -7/2 issued in the ready cycle
        issue(1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        expect_run(1, 9, 0, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        issue(1, OP_REM, 32'hFFFF_FFF9, 32'd2);
        expect_run(1, 9, 0, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "rem_m7_2");
        tick();

        // Reset mid-CALC
        issue(0, OP_DIVU, 32'd77, 32'd5);
        tick();
        start[0] = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        expect_cleared(0, "rst_mid");
        rst = 1'b0;
        tick();

        // Complete once, then reset mid-CALC together with kill
        issue(0, OP_REMU, 32'd77, 32'd5);
        expect_run(0, 33, 0, 0, 32'd15, 32'd2, 32'd2, "remu77_5");
        tick();
        issue(0, OP_DIV, 32'd77, 32'd5);
        tick();
        start[0] = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        kill[0] = 1'b1;
        tick();
        expect_cleared(0, "rst_kill_mid");
        rst = 1'b0;
        kill[0] = 1'b0;
        tick();
        chk("rst_kill idle busy", {31'b0, busy[0]}, 32'd0);

        // Randomised 16-bit sweep across BPC 1/2/4
        for (int t = 0; t < 60; t++) begin
            o = 4'b0001 << $urandom_range(0, 3);
            a = $urandom & 32'h0000_FFFF;
            b = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_000F;
            case (t)
                0: begin o = OP_DIV;  a = 32'h8000; b = 32'hFFFF; end
                1: begin o = OP_REM;  a = 32'h8000; b = 32'hFFFF; end
                2: begin o = OP_DIVU; b = 32'd0; end
                3: begin o = OP_REM;  a = a | 32'h8000; b = 32'd0; end
                4: begin o = OP_DIVU; a = 32'h8000; b = 32'hFFFF; end
                default: ;
            endcase
            ref_div(16, o, a, b, eq, er);
            eres = ((o == OP_REM) || (o == OP_REMU)) ? er : eq;
            sgn  = (o == OP_DIV) || (o == OP_REM);
            sp   = (b == 32'd0) || (sgn && a == 32'h8000 && b == 32'hFFFF);
            for (int k = 2; k < NI; k++) issue(k, o, a, b);
            for (int c = 1; c <= 17; c++) begin
                tick();
                if (c == 1) for (int k = 2; k < NI; k++) start[k] = 1'b0;
                for (int k = 2; k < NI; k++) begin
                    lat = sp ? 1 : (16 / bpc_of(k)) + 1;
                    chk($sformatf("sweep%0d i%0d busy c%0d", t, k, c),
                        {31'b0, busy[k]}, {31'b0, (c < lat) ? 1'b1 : 1'b0});
                    chk($sformatf("sweep%0d i%0d ready c%0d", t, k, c),
                        {31'b0, ready[k]}, {31'b0, (c == lat) ? 1'b1 : 1'b0});
                    if (c == lat) begin
                        chk($sformatf("sweep%0d i%0d op%h %h/%h q", t, k, o, a, b), quo_o[k], eq);
                        chk($sformatf("sweep%0d i%0d op%h %h/%h r", t, k, o, a, b), rem_o[k], er);
                        chk($sformatf("sweep%0d i%0d op%h %h/%h res", t, k, o, a, b), res_o[k], eres);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
